dram_multi_port_frontend: RTL and testbench

Parametrised N-port request front-end for the simulated DRAM model. It accepts word-granular read/write requests from NumPorts independent clients and arbitrates them, round-robin or read-priority with write anti-starvation. It aligns each address and rebases it against Base, then issues one request stream to the DRAM model through a registered output stage. Read data and write acknowledgements are routed back to the originating port in order, and the number of in-flight transactions is bounded.

---
 rtl/dram_multi_port_frontend.sv | 164 ++++++++++++++++
 tb/tb_dram_multi_port_frontend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_multi_port_frontend.sv
// dram_multi_port_frontend: N-port arbitrated DRAM request front-end with in-order response routing
// Port-index FIFO remembering which client owns each in-flight response.
module dram_mpf_fifo #(
  parameter int Depth = 16,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(Depth);
  logic [W-1:0] mem [Depth];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head = mem[rp];
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(Depth);
endmodule

module dram_multi_port_frontend #(
  parameter int          NumPorts       = 4,
  parameter int          AddrWidth      = 32,
  parameter int          DataWidth      = 512,
  parameter logic [63:0] Base           = 64'h8000_0000,
  parameter int          MaxOutstanding = 16,
  parameter int          ArbMode        = 0,
  parameter int          StarveLimit    = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               req_valid_i,
  output logic [NumPorts-1:0]               req_ready_o,
  input  logic [NumPorts-1:0]               req_we_i,
  input  logic [NumPorts*AddrWidth-1:0]     req_addr_i,
  input  logic [NumPorts*DataWidth-1:0]     req_wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0]   req_wstrb_i,
  output logic [NumPorts-1:0]               rd_valid_o,
  input  logic [NumPorts-1:0]               rd_ready_i,
  output logic [DataWidth-1:0]              rd_data_o,
  output logic [NumPorts-1:0]               b_valid_o,
  input  logic [NumPorts-1:0]               b_ready_i,
  output logic                              dram_req_valid_o,
  input  logic                              dram_req_ready_i,
  output logic                              dram_we_o,
  output logic [AddrWidth-1:0]              dram_addr_o,
  output logic [DataWidth-1:0]              dram_wdata_o,
  output logic [DataWidth/8-1:0]            dram_wstrb_o,
  input  logic                              dram_rsp_valid_i,
  output logic                              dram_rsp_ready_o,
  input  logic [DataWidth-1:0]              dram_rdata_i,
  input  logic                              dram_b_valid_i,
  output logic                              dram_b_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);
  localparam int PW = $clog2(NumPorts);
  localparam int SW = DataWidth / 8;
  localparam int OFF = $clog2(SW);
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int CW = $clog2(StarveLimit + 1);
  localparam logic [AddrWidth-1:0] BaseA = Base[AddrWidth-1:0];
  localparam logic [NumPorts-1:0] One = 1;

  logic [PW-1:0] ptr, gnt, rd_head, b_head;
  logic [PW:0] idx;
  logic [NumPorts-1:0] elig, rd_m, wr_m, cand;
  logic found, wr_any, force_w, can_acc, acc, gnt_we;
  logic rd_empty, rd_full, b_empty, b_full, rd_hs, b_hs;
  logic [CW-1:0] starve_cnt;
  logic [AddrWidth-1:0] gnt_addr;

  // Ports whose routing FIFO is full are masked before arbitration.
  always_comb begin
    elig = req_valid_i & ~(req_we_i & {NumPorts{b_full}}) & ~(~req_we_i & {NumPorts{rd_full}});
    rd_m = elig & ~req_we_i;
    wr_m = elig & req_we_i;
    wr_any = |(req_valid_i & req_we_i);
    force_w = starve_cnt == CW'(StarveLimit) && wr_any;
    cand = ArbMode == 0 ? elig : force_w ? wr_m : |rd_m ? rd_m : wr_m;
    can_acc = !rst_i && (!dram_req_valid_o || dram_req_ready_i) && outstanding_o < OW'(MaxOutstanding);
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      idx = idx >= (PW+1)'(NumPorts) ? idx - (PW+1)'(NumPorts) : idx;
      if (!found && cand[idx[PW-1:0]]) begin
        found = 1'b1;
        gnt = idx[PW-1:0];
      end
    end
    acc = can_acc && found;
    gnt_we = req_we_i[gnt];
    gnt_addr = req_addr_i[gnt*AddrWidth +: AddrWidth];
    req_ready_o = acc ? One << gnt : '0;
    rd_valid_o = !rst_i && dram_rsp_valid_i && !rd_empty ? One << rd_head : '0;
    b_valid_o = !rst_i && dram_b_valid_i && !b_empty ? One << b_head : '0;
    dram_rsp_ready_o = !rst_i && (rd_empty || rd_ready_i[rd_head]);
    dram_b_ready_o = !rst_i && (b_empty || b_ready_i[b_head]);
    rd_hs = dram_rsp_valid_i && dram_rsp_ready_o && !rd_empty;
    b_hs = dram_b_valid_i && dram_b_ready_o && !b_empty;
  end

  assign rd_data_o = dram_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dram_req_valid_o <= 1'b0;
    end else if (acc) begin
      dram_req_valid_o <= 1'b1;
      dram_we_o <= gnt_we;
      dram_addr_o <= {gnt_addr[AddrWidth-1:OFF], OFF'(0)} - BaseA;
      dram_wdata_o <= req_wdata_i[gnt*DataWidth +: DataWidth];
      dram_wstrb_o <= req_wstrb_i[gnt*SW +: SW];
    end else if (dram_req_ready_i) begin
      dram_req_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      starve_cnt <= '0;
      outstanding_o <= '0;
    end else begin
      if (acc) ptr <= gnt == PW'(NumPorts - 1) ? '0 : gnt + 1'b1;
      if (!wr_any || (acc && gnt_we)) starve_cnt <= '0;
      else if (acc && starve_cnt < CW'(StarveLimit)) starve_cnt <= starve_cnt + 1'b1;
      outstanding_o <= outstanding_o + OW'(acc) - OW'(rd_hs) - OW'(b_hs);
    end
  end

  dram_mpf_fifo #(.Depth(MaxOutstanding), .W(PW)) u_rd_fifo (
    .clk(clk_i), .rst(rst_i), .push(acc && !gnt_we), .pop(rd_hs), .din(gnt),
    .head(rd_head), .empty(rd_empty), .full(rd_full)
  );

  dram_mpf_fifo #(.Depth(MaxOutstanding), .W(PW)) u_b_fifo (
    .clk(clk_i), .rst(rst_i), .push(acc && gnt_we), .pop(b_hs), .din(gnt),
    .head(b_head), .empty(b_empty), .full(b_full)
  );

  // A response with no owner is consumed and dropped; it indicates a DRAM model error.
  a_rd_orphan: assert property (@(posedge clk_i) disable iff (rst_i) dram_rsp_valid_i |-> !rd_empty);
  a_b_orphan: assert property (@(posedge clk_i) disable iff (rst_i) dram_b_valid_i |-> !b_empty);
endmodule

// File: tb/tb_dram_multi_port_frontend.sv
// tb_dram_multi_port_frontend: randomized and directed checks against a queue-based reference model
module tb_dram_multi_port_frontend;
  localparam int NP = 4, AW = 32, DW = 64, SW = DW / 8, MO = 4, SL = 2, OW = $clog2(MO + 1);
  logic clk = 1'b0, rst;
  logic [NP-1:0] req_valid, req_ready, req_we, rd_valid, rd_ready, b_valid, b_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*SW-1:0] req_wstrb;
  logic [DW-1:0] rd_data, dram_wdata, dram_rdata;
  logic [SW-1:0] dram_wstrb;
  logic [AW-1:0] dram_addr;
  logic dram_req_valid, dram_req_ready, dram_we, dram_rsp_valid, dram_rsp_ready, dram_b_valid, dram_b_ready;
  logic [OW-1:0] outstanding;

  always #5 clk = ~clk;

  dram_multi_port_frontend #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .Base(64'h8000_0000),
    .MaxOutstanding(MO), .ArbMode(1), .StarveLimit(SL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .b_valid_o(b_valid), .b_ready_i(b_ready),
    .dram_req_valid_o(dram_req_valid), .dram_req_ready_i(dram_req_ready),
    .dram_we_o(dram_we), .dram_addr_o(dram_addr), .dram_wdata_o(dram_wdata), .dram_wstrb_o(dram_wstrb),
    .dram_rsp_valid_i(dram_rsp_valid), .dram_rsp_ready_o(dram_rsp_ready), .dram_rdata_i(dram_rdata),
    .dram_b_valid_i(dram_b_valid), .dram_b_ready_o(dram_b_ready),
    .outstanding_o(outstanding)
  );

  int n_vec, n_err;
  int m_out, m_ptr, m_starve, pend_rd, pend_b;
  int m_rq[$], m_bq[$];
  bit m_valid, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [NP-1:0] last_ready;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reads beat writes, round-robin within a class; a write is forced after SL starving read grants.
  function automatic int pick();
    bit [NP-1:0] r, w, c;
    r = req_valid & ~req_we & {NP{m_rq.size() < MO}};
    w = req_valid & req_we & {NP{m_bq.size() < MO}};
    if (m_starve == SL && (req_valid & req_we) != 0) c = w;
    else c = r != 0 ? r : w;
    for (int k = 0; k < NP; k++)
      if (c[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
    return -1;
  endfunction

  task automatic step();
    int g, rh, bh;
    bit ok, rhs, bhs;
    #1;
    rh = m_rq.size() > 0 ? m_rq[0] : -1;
    bh = m_bq.size() > 0 ? m_bq[0] : -1;
    ok = !rst && (!m_valid || dram_req_ready) && m_out < MO;
    g = ok ? pick() : -1;
    last_ready = req_ready;
    check("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'd1 << g);
    check("dram_req_valid", 64'(dram_req_valid), 64'(m_valid));
    if (m_valid) begin
      check("dram_we", 64'(dram_we), 64'(m_we));
      check("dram_addr", 64'(dram_addr), 64'(m_addr));
      if (m_we) begin
        check("dram_wdata", dram_wdata, m_wdata);
        check("dram_wstrb", 64'(dram_wstrb), 64'(m_wstrb));
      end
    end
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("rd_valid", 64'(rd_valid), (!rst && dram_rsp_valid && rh >= 0) ? 64'd1 << rh : 64'd0);
    check("b_valid", 64'(b_valid), (!rst && dram_b_valid && bh >= 0) ? 64'd1 << bh : 64'd0);
    check("rsp_ready", 64'(dram_rsp_ready), rst ? 64'd0 : rh < 0 ? 64'd1 : 64'(rd_ready[rh]));
    check("b_ready", 64'(dram_b_ready), rst ? 64'd0 : bh < 0 ? 64'd1 : 64'(b_ready[bh]));
    if (rd_valid != 0) check("rd_data", rd_data, dram_rdata);
    rhs = !rst && dram_rsp_valid && rh >= 0 && rd_ready[rh];
    bhs = !rst && dram_b_valid && bh >= 0 && b_ready[bh];
    if (rst) begin
      m_out = 0; m_ptr = 0; m_starve = 0; pend_rd = 0; pend_b = 0;
      m_rq.delete(); m_bq.delete(); m_valid = 0;
    end else begin
      if (m_valid && dram_req_ready) begin
        if (m_we) pend_b++; else pend_rd++;
        m_valid = 0;
      end
      if (rhs) begin void'(m_rq.pop_front()); pend_rd--; end
      if (bhs) begin void'(m_bq.pop_front()); pend_b--; end
      if ((req_valid & req_we) == 0 || (g >= 0 && req_we[g])) m_starve = 0;
      else if (g >= 0 && m_starve < SL) m_starve++;
      if (g >= 0) begin
        m_valid = 1;
        m_we = req_we[g];
        m_addr = (req_addr[g*AW +: AW] & ~AW'(SW - 1)) - 32'h8000_0000;
        m_wdata = req_wdata[g*DW +: DW];
        m_wstrb = req_wstrb[g*SW +: SW];
        if (req_we[g]) m_bq.push_back(g); else m_rq.push_back(g);
        m_ptr = (g + 1) % NP;
      end
      m_out = m_out + int'(g >= 0) - int'(rhs) - int'(bhs);
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AW +: AW] = $urandom;
      req_wdata[p*DW +: DW] = {$urandom, $urandom};
      req_wstrb[p*SW +: SW] = SW'($urandom);
    end
    dram_rdata = {$urandom, $urandom};
  endtask

  task automatic idle();
    rand_payload();
    req_valid = '0; req_we = '0; rd_ready = '1; b_ready = '1; dram_req_ready = 1'b1;
    dram_rsp_valid = pend_rd > 0;
    dram_b_valid = pend_b > 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_out != 0 || m_valid) && n < 50) begin
      idle(); step(); n++;
    end
    check("drain_done", 64'(m_out != 0 || m_valid), 64'd0);
  endtask

  int acc_cnt;
  logic [23:0] seq;

  initial begin
    rst = 1'b1;
    pend_rd = 0; pend_b = 0;
    idle();
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    // Single read, port 1, example address
    idle(); req_valid = 4'b0010; req_addr[1*AW +: AW] = 32'h8000_0047; step();
    check("ex_ready", 64'(last_ready), 64'b0010);
    idle(); #1; check("ex_addr", 64'(dram_addr), 64'h40); step();
    idle(); dram_rsp_valid = 1'b1; dram_rdata = {8{8'hAB}}; rd_ready = 4'b0010; step();
    check("ex_out", 64'(outstanding), 64'd0);
    drain();
    // Starvation: port0 reads, port1 writes
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      idle(); req_valid = 4'b0011; req_we = 4'b0010; step();
      seq = {seq[19:0], last_ready};
    end
    check("starve_seq", 64'(seq), 64'h112112);
    drain();
    // Outstanding cap with a silent DRAM
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(); req_valid = '1; dram_rsp_valid = 0; dram_b_valid = 0; step();
      acc_cnt += int'(last_ready != 0);
    end
    check("cap_acc", 64'(acc_cnt), 64'd4);
    #1 check("cap_out", 64'(outstanding), 64'd4);
    idle(); req_valid = '1; dram_rsp_valid = 1; dram_b_valid = 0; step();
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); req_valid = '1; dram_rsp_valid = 0; dram_b_valid = 0; step();
      acc_cnt += int'(last_ready != 0);
    end
    check("cap_one_more", 64'(acc_cnt), 64'd1);
    drain();
    // Simultaneous rd handshake, b handshake and accept from 3 outstanding
    idle(); req_valid = 4'b0001; dram_rsp_valid = 0; dram_b_valid = 0; step();
    idle(); req_valid = 4'b0010; req_we = 4'b0010; dram_rsp_valid = 0; dram_b_valid = 0; step();
    idle(); req_valid = 4'b0100; dram_rsp_valid = 0; dram_b_valid = 0; step();
    idle(); dram_rsp_valid = 0; dram_b_valid = 0; step();
    #1 check("three_out", 64'(outstanding), 64'd3);
    idle(); req_valid = 4'b1000; dram_rsp_valid = 1; dram_b_valid = 1; step();
    #1 check("net_minus_one", 64'(outstanding), 64'd2);
    drain();
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_payload();
      req_valid = NP'($urandom); req_we = NP'($urandom);
      rd_ready = NP'($urandom); b_ready = NP'($urandom);
      dram_req_ready = ($urandom % 100) < (((i / 200) % 2) ? 30 : 85);
      dram_rsp_valid = pend_rd > 0 && ($urandom % 100) < (((i / 150) % 2) ? 10 : 70);
      dram_b_valid = pend_b > 0 && ($urandom % 100) < 60;
      step();
    end
    // Reset with traffic in flight
    for (int i = 0; i < 6; i++) begin
      idle(); req_valid = '1; req_we = 4'b0101; dram_req_ready = 0; dram_rsp_valid = 0; dram_b_valid = 0; step();
    end
    rst = 1'b1; idle(); req_valid = '1; dram_req_ready = 0; dram_rsp_valid = 0; dram_b_valid = 0; step();
    rst = 1'b0; idle(); #1;
    check("rst_out", 64'(outstanding), 64'd0);
    check("rst_valid", 64'(dram_req_valid), 64'd0);
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 32'h8000_1000; step();
    idle(); #1; check("post_rst_addr", 64'(dram_addr), 64'h1000); step();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
